// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with configurable wait states.
// Optional build macro DMEM_MISALIGN_CHECK_EN flags accesses with addr[1:0]!=0 as errors and suppresses them.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept_c;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               misalign_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   idx_c;

    logic [DATA_W-1:0]  mem [DEPTH_WORDS];

    assign idx_c = addr_q[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;

    assign misalign_c = (addr_q[1:0] != 2'b00);

    // Error flag is captured alongside the data in the access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            err_q <= misalign_c;
        end
    end

    assign resp_err = err_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^addr_q[1:0];
    assign misalign_c      = 1'b0;
    assign resp_err        = 1'b0;
`endif

    // Next-state logic; the request is only taken while the registered ready is high (IDLE).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, handshake decodes and the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            if (accept_c) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_ACCESS) begin
                rdata_q <= (write_q || misalign_c) ? '0 : mem[idx_c];
            end
        end
    end

    // Array has no reset; a store landing on a reset edge is dropped.
    assign mem_we_c = !rst && (state_q == ST_ACCESS) && write_q && !misalign_c;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS datapath: it accepts one load or store request at a time from the datapath's memory port over a valid/ready handshake. It inserts a configurable number of wait states, performs the word access on a local RAM array and returns the result over a second valid/ready handshake. It replaces the zero-latency data memory so that the processor's stall and handshake logic can be exercised against realistic memory timing.

## Interface

- `ADDR_W`, default 12: byte-address width; matches the 12-bit PC/address space.
- `DEPTH_WORDS`, default 1024: number of 32-bit words, equal to 2**(ADDR_W-2).
- `WAIT_CYCLES`, default 2: wait states inserted between request accept and the array access. Legal range 0..15.

Ports. Reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present. Held with its payload stable until accepted.
- `req_ready`  out  1  responder can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  response present; held until `resp_ready`.
- `resp_ready`  in  1  datapath accepts the response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access; see Configuration.

## Operation

- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_write`, `req_addr` and `req_wdata`.
  - If `WAIT_CYCLES`>0: load wait counter with `WAIT_CYCLES`-1 and go to WAIT. Otherwise go to ACCESS.
- WAIT
  - If counter==0, go to ACCESS; otherwise decrement the counter.
  - `req_ready`=0.
- ACCESS, one cycle; word index = latched addr[ADDR_W-1:2].
  - Store: write `wdata` to the array and register `rdata`=0.
  - Load: register `rdata`=array[index].
  - Go to RESP.
- RESP
  - `resp_valid`=1, with `resp_rdata` and `resp_err` stable.
  - On `resp_ready`, go to IDLE.
  - If `resp_ready` is low, stay in RESP indefinitely; no new request is accepted.
- Only one transaction is outstanding at a time. Requests arriving outside IDLE are not accepted, since `req_ready`=0.
- `req_valid` deasserting while `req_ready`=0 has no effect.
- The array is not cleared by `rst`; contents are retained across reset. A read of a never-written word returns X.
- Store followed by load to the same address returns the stored value; there is no forwarding hazard because the two transactions are serialized.

## Timing

- Reset values: state=IDLE, `req_ready`=1 in the first cycle after reset, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- Reset mid-operation: any state returns to IDLE on the reset edge, and the latched request is discarded.
  - A store whose ACCESS cycle coincides with `rst`=1 is NOT written; reset has priority.
- Latency: request accepted at edge E0 means `resp_valid` is high after edge E0+`WAIT_CYCLES`+1.
  - Example: `WAIT_CYCLES`=2, accept at E0, `resp_valid` high after E3.
- Response handshake at edge Er means IDLE and `req_ready`=1 after Er. The earliest next accept is at Er+1.
- Maximum throughput is one transaction per `WAIT_CYCLES`+3 cycles.
- `req_ready` is a registered state decode with no combinational path from `req_valid`. `resp_valid` is also a registered state decode.

## Configuration

- `DMEM_MISALIGN_CHECK_EN` defined:
  - An accepted request with addr[1:0]!=0 passes through WAIT and ACCESS normally, but the array is neither read nor written.
  - The response carries `resp_err`=1 and `resp_rdata`=0.
- `DMEM_MISALIGN_CHECK_EN` undefined:
  - addr[1:0] is ignored and the access goes to word addr[ADDR_W-1:2].
  - `resp_err` is tied to 0.

## Test plan

- Reset, then store 0xDEADBEEF at 0x010, then load 0x010 with `WAIT_CYCLES`=2 -> load `resp_valid` rises 3 edges after accept, `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- `WAIT_CYCLES`=0: load at 0x000 after storing 0x00000001 -> `resp_valid` 1 edge after accept, `resp_rdata`=0x00000001.
- Backpressure: hold `resp_ready`=0 for 5 cycles with `req_valid`=1 -> `req_ready` stays 0, `resp_valid`, `resp_rdata` and `resp_err` stay stable; one cycle after `resp_ready`=1, `req_ready`=1.
- Store 0x12345678 to 0x007:
  - With `DMEM_MISALIGN_CHECK_EN`: `resp_err`=1, and a load of 0x004 returns the prior value unchanged.
  - Without it: `resp_err`=0, and a load of 0x004 returns 0x12345678.
- Assert `rst` in the ACCESS cycle of a store of 0xCAFEF00D to 0x020 that had been preceded by a store of 0x11111111 -> next cycle state IDLE, `resp_valid`=0; a subsequent load of 0x020 returns 0x11111111.
- Highest word 0xFFC: store 0xA5A5A5A5 then load -> 0xA5A5A5A5; word 0x000 is unaffected, so there is no wrap aliasing.
